// File: rtl/ma_cvxif_pkg.sv
// Shared types and constants for the matrix-accelerator CV-X-IF bridge.
// Contents: entry state enum, queue entry struct, custom-0 opcode and the
// list of accepted funct3 values with a lookup helper.
package ma_cvxif_pkg;

  localparam int unsigned MA_XLEN = 32;
  localparam int unsigned MA_ID_W = 3;

  localparam logic [6:0] MA_CUSTOM0_OPCODE = 7'b0001011;

  localparam int unsigned MA_NUM_FUNCT3 = 4;
  localparam logic [2:0] MA_FUNCT3_LIST [MA_NUM_FUNCT3] = '{3'b000, 3'b001, 3'b100, 3'b101};

  typedef enum logic [2:0] {
    FREE,
    PENDING,
    COMMITTED,
    KILLED,
    SENT,
    DONE
  } entry_state_e;

  typedef struct packed {
    logic [MA_ID_W-1:0] id;
    logic [9:0]         funct;
    logic [4:0]         rd;
    logic [MA_XLEN-1:0] rs1;
    logic [MA_XLEN-1:0] rs2;
    logic               we;
    logic [MA_XLEN-1:0] data;
    entry_state_e       state;
  } entry_t;

  function automatic logic funct3_accepted(input logic [2:0] funct3);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < MA_NUM_FUNCT3; i++) begin
      if (MA_FUNCT3_LIST[i] == funct3) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ma_cvxif_decoder.sv
// Combinational custom-0 decode.
// Ports: instr (instruction word) -> accept (instruction belongs to the
// accelerator), writeback (accepted and will write a non-zero rd).
module ma_cvxif_decoder
  import ma_cvxif_pkg::*;
(
  input  logic [31:0] instr,
  output logic        accept,
  output logic        writeback
);

  logic unused_instr_bits;

  always_comb begin
    accept            = (instr[6:0] == MA_CUSTOM0_OPCODE) && funct3_accepted(instr[14:12]);
    writeback         = accept && instr[14] && (instr[11:7] != 5'd0);
    unused_instr_bits = ^instr[31:15];
  end

endmodule

// File: rtl/ma_cvxif_bridge.sv
// CV-X-IF bridge between the CVA6 core and the matrix accelerator.
// Accepted custom-0 instructions are queued in order, committed or killed by
// the core, dispatched from the head one at a time, and their results are
// returned over the result handshake.
// Ports: issue_* (core issue i/f), commit_* (commit/kill strobe),
// acc_* (accelerator request/response), result_* (core result i/f).
// Optional: define MA_CVXIF_BRIDGE_PERF_EN to add perf_issued_o,
// perf_rejected_o and perf_killed_o event counters.
module ma_cvxif_bridge
  import ma_cvxif_pkg::*;
#(
  parameter int unsigned XLEN    = MA_XLEN,
  parameter int unsigned IdWidth = MA_ID_W,
  parameter int unsigned Depth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               acc_req_valid_o,
  input  logic               acc_req_ready_i,
  output logic [9:0]         acc_funct_o,
  output logic [XLEN-1:0]    acc_rs1_o,
  output logic [XLEN-1:0]    acc_rs2_o,
  input  logic               acc_rsp_valid_i,
  input  logic [XLEN-1:0]    acc_rsp_data_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
`ifdef MA_CVXIF_BRIDGE_PERF_EN
  ,
  output logic [31:0]        perf_issued_o,
  output logic [31:0]        perf_rejected_o,
  output logic [31:0]        perf_killed_o
`endif
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PTR_ONE = 1;

  entry_t            entries_q [Depth];
  logic [AW:0]       head_q, tail_q;
  logic [AW-1:0]     head_idx, tail_idx;
  logic              full;
  logic              dec_accept, dec_wb;
  logic              issue_fire;
  logic [Depth-1:0]  commit_match;
  entry_t            head;

  ma_cvxif_decoder u_decoder (
    .instr     (issue_instr_i),
    .accept    (dec_accept),
    .writeback (dec_wb)
  );

  always_comb begin
    head_idx = head_q[AW-1:0];
    tail_idx = tail_q[AW-1:0];
    head     = entries_q[head_idx];
    // Extra pointer bit tells full (wrapped) from empty when indices match.
    full     = (head_q[AW] != tail_q[AW]) && (head_idx == tail_idx);

    issue_ready_o     = !full;
    issue_fire        = issue_valid_i && issue_ready_o;
    issue_accept_o    = issue_valid_i && dec_accept;
    issue_writeback_o = issue_valid_i && dec_wb;

    // Match uses registered state, so a commit in the issue cycle sees FREE.
    for (int unsigned i = 0; i < Depth; i++) begin
      commit_match[i] = commit_valid_i && (entries_q[i].state == PENDING) &&
                        (entries_q[i].id == commit_id_i);
    end

    acc_req_valid_o = (head.state == COMMITTED);
    acc_funct_o     = acc_req_valid_o ? head.funct : '0;
    acc_rs1_o       = acc_req_valid_o ? head.rs1   : '0;
    acc_rs2_o       = acc_req_valid_o ? head.rs2   : '0;

    result_valid_o  = (head.state == DONE);
    result_id_o     = result_valid_o ? head.id   : '0;
    result_data_o   = result_valid_o ? head.data : '0;
    result_rd_o     = result_valid_o ? head.rd   : '0;
    result_we_o     = result_valid_o && head.we;
  end

  // Issue writes a FREE slot, commit touches PENDING slots and the head
  // update handles the later states, so the three never collide on a slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) entries_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (commit_match[i]) entries_q[i].state <= commit_kill_i ? KILLED : COMMITTED;
      end

      if (issue_fire && dec_accept) begin
        entries_q[tail_idx] <= '{id:    issue_id_i,
                                 funct: {issue_instr_i[31:25], issue_instr_i[14:12]},
                                 rd:    issue_instr_i[11:7],
                                 rs1:   issue_rs1_i,
                                 rs2:   issue_rs2_i,
                                 we:    dec_wb,
                                 data:  '0,
                                 state: PENDING};
        tail_q <= tail_q + PTR_ONE;
      end

      case (head.state)
        COMMITTED: if (acc_req_ready_i) entries_q[head_idx].state <= SENT;
        SENT: begin
          if (acc_rsp_valid_i) begin
            entries_q[head_idx].state <= DONE;
            entries_q[head_idx].data  <= head.we ? acc_rsp_data_i : '0;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            entries_q[head_idx].state <= FREE;
            head_q <= head_q + PTR_ONE;
          end
        end
        KILLED: begin
          entries_q[head_idx].state <= FREE;
          head_q <= head_q + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef MA_CVXIF_BRIDGE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o   <= '0;
      perf_rejected_o <= '0;
      perf_killed_o   <= '0;
    end else begin
      if (issue_fire && dec_accept)  perf_issued_o   <= perf_issued_o + 32'd1;
      if (issue_fire && !dec_accept) perf_rejected_o <= perf_rejected_o + 32'd1;
      if ((|commit_match) && commit_kill_i) perf_killed_o <= perf_killed_o + 32'd1;
    end
  end
`endif

endmodule
